// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding, default width and counter sizing for the divider.
package div_ctrl_pkg;

  localparam int unsigned DIV_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Width of the iteration counter for a given operand width.
  function automatic int unsigned div_count_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_ctrl_step.sv
// div_ctrl_step: one combinational radix-2 restoring iteration (shift, trial subtract, quotient bit).
module div_ctrl_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   i_rem,
  input  logic [DATA_WIDTH-1:0] i_quo,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH:0]   o_rem,
  output logic [DATA_WIDTH-1:0] o_quo
);

  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH+1:0] w_diff;
  logic                  w_no_borrow;

  // Bring the next dividend bit into the partial remainder.
  assign w_shift = {i_rem[DATA_WIDTH-1:0], i_quo[DATA_WIDTH-1]};

  // Trial subtract; a set top remainder bit means the shifted value exceeds any divisor.
  assign w_diff      = {1'b0, w_shift} - {2'b0, i_divisor};
  assign w_no_borrow = i_rem[DATA_WIDTH] | ~w_diff[DATA_WIDTH+1];

  // Restore on borrow, otherwise keep the difference and record a 1 quotient bit.
  assign o_rem = w_no_borrow ? w_diff[DATA_WIDTH:0] : w_shift;
  assign o_quo = {i_quo[DATA_WIDTH-2:0], w_no_borrow};

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divide sequencer for the EX stage.
// Optional macro DIV_SIGNED_EN adds signed divide selected by signed_flag.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  signed_flag,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  cancel,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned            CW                = div_count_width(DATA_WIDTH);
  localparam logic [CW-1:0]          LAST_COUNT        = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0]  DIV_ZERO_QUOTIENT = '1;

  div_state_e            r_state;
  div_state_e            w_state_next;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH:0]   r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;

  logic                  w_accept;
  logic                  w_iterate;
  logic                  w_divisor_zero;
  logic                  w_last;
  logic [DATA_WIDTH:0]   w_rem_next;
  logic [DATA_WIDTH-1:0] w_quo_next;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;
  logic [DATA_WIDTH-1:0] w_q_final;
  logic [DATA_WIDTH-1:0] w_r_final;

  assign w_divisor_zero = (divisor == '0);
  assign w_last         = (r_count == LAST_COUNT);

`ifdef DIV_SIGNED_EN
  logic w_a_neg;
  logic w_b_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_a_neg = signed_flag & dividend[DATA_WIDTH-1];
  assign w_b_neg = signed_flag & divisor[DATA_WIDTH-1];
  assign w_a_mag = w_a_neg ? -dividend : dividend;
  assign w_b_mag = w_b_neg ? -divisor  : divisor;

  // Result sign fix-ups captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end
  end

  assign w_q_final = r_neg_q ? -w_quo_next : w_quo_next;
  assign w_r_final = r_neg_r ? -w_rem_next[DATA_WIDTH-1:0] : w_rem_next[DATA_WIDTH-1:0];
`else
  logic w_unused_signed_flag;

  assign w_unused_signed_flag = signed_flag;
  assign w_a_mag   = dividend;
  assign w_b_mag   = divisor;
  assign w_q_final = w_quo_next;
  assign w_r_final = w_rem_next[DATA_WIDTH-1:0];
`endif

  div_ctrl_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; cancel overrides every transition.
  always_comb begin
    w_state_next = r_state;
    if (cancel) begin
      w_state_next = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: if (start) w_state_next = w_divisor_zero ? DIV_DONE : DIV_CALC;
        DIV_CALC: if (w_last) w_state_next = DIV_DONE;
        DIV_DONE: w_state_next = DIV_IDLE;
        default:  w_state_next = DIV_IDLE;
      endcase
    end
  end

  // Output decode: stall while accepting or iterating; released in DONE so the instruction retires.
  always_comb begin
    stall_req = 1'b0;
    w_accept  = 1'b0;
    w_iterate = 1'b0;
    if (rst_n && !cancel) begin
      case (r_state)
        DIV_IDLE: begin
          w_accept  = start;
          stall_req = start;
        end
        DIV_CALC: begin
          w_iterate = 1'b1;
          stall_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Done pulse raised on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_state_next == DIV_DONE);
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (cancel) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= w_a_mag;
      r_divisor <= w_b_mag;
      if (w_divisor_zero) begin
        r_quotient  <= DIV_ZERO_QUOTIENT;
        r_remainder <= dividend;
      end
    end else if (w_iterate) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_quotient  <= w_q_final;
        r_remainder <= w_r_final;
      end
    end
  end

  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
